// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants: display field widths, time moduli and default prescaler ratio.
// Used by the control FSM, this datapath and the FND display decoder.
package stopwatch_pkg;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam int MSEC_MOD = 100;
    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HOUR_MOD = 24;

    // 100 MHz system clock down to a 1/100 s tick
    localparam int TICK_DIV_DEFAULT = 1_000_000;

endpackage

// File: rtl/stopwatch_dp_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled clocks; the partial
// count is kept while disabled so a paused stopwatch resumes without losing the fraction.
module tick_gen
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             at_last;

    assign at_last = (cnt_reg == CNT_LAST);
    assign o_tick  = i_en && !i_clear && at_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (i_clear) begin
            cnt_reg <= '0;
        end else if (i_en) begin
            cnt_reg <= at_last ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_dp.sv
// Stopwatch datapath: 1/100 s prescaler plus msec/sec/min/hour wrap-around cascade.
// Optional lap snapshot display enabled by defining STOPWATCH_DP_LAP_EN.
module stopwatch_dp
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int MSEC_MAX = MSEC_MOD,
    parameter int SEC_MAX  = SEC_MOD,
    parameter int MIN_MAX  = MIN_MOD,
    parameter int HOUR_MAX = HOUR_MOD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run,
    input  logic              i_clear,
`ifdef STOPWATCH_DP_LAP_EN
    input  logic              i_lap,
    output logic              o_lap_hold,
`endif
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour
);

    logic tick;
    logic carry_sec, carry_min, carry_hour;

    logic [MSEC_W-1:0] msec_reg, msec_next;
    logic [SEC_W-1:0]  sec_reg,  sec_next;
    logic [MIN_W-1:0]  min_reg,  min_next;
    logic [HOUR_W-1:0] hour_reg, hour_next;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .i_en    (i_run),
        .i_clear (i_clear),
        .o_tick  (tick)
    );

    // Carries ripple combinationally so every field moves on the same edge
    assign carry_sec  = tick      && (msec_reg == MSEC_W'(MSEC_MAX - 1));
    assign carry_min  = carry_sec && (sec_reg  == SEC_W'(SEC_MAX - 1));
    assign carry_hour = carry_min && (min_reg  == MIN_W'(MIN_MAX - 1));

    always_comb begin
        msec_next = msec_reg;
        sec_next  = sec_reg;
        min_next  = min_reg;
        hour_next = hour_reg;
        if (i_clear) begin
            msec_next = '0;
            sec_next  = '0;
            min_next  = '0;
            hour_next = '0;
        end else begin
            if (tick)       msec_next = carry_sec  ? '0 : msec_reg + 1'b1;
            if (carry_sec)  sec_next  = carry_min  ? '0 : sec_reg + 1'b1;
            if (carry_min)  min_next  = carry_hour ? '0 : min_reg + 1'b1;
            if (carry_hour) hour_next = (hour_reg == HOUR_W'(HOUR_MAX - 1)) ? '0 : hour_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msec_reg <= '0;
            sec_reg  <= '0;
            min_reg  <= '0;
            hour_reg <= '0;
        end else begin
            msec_reg <= msec_next;
            sec_reg  <= sec_next;
            min_reg  <= min_next;
            hour_reg <= hour_next;
        end
    end

`ifdef STOPWATCH_DP_LAP_EN
    logic              lap_hold_reg;
    logic [MSEC_W-1:0] lap_msec_reg;
    logic [SEC_W-1:0]  lap_sec_reg;
    logic [MIN_W-1:0]  lap_min_reg;
    logic [HOUR_W-1:0] lap_hour_reg;

    // Snapshot samples the registered fields, i.e. the value before any same-cycle tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_hold_reg <= 1'b0;
            lap_msec_reg <= '0;
            lap_sec_reg  <= '0;
            lap_min_reg  <= '0;
            lap_hour_reg <= '0;
        end else if (i_clear) begin
            lap_hold_reg <= 1'b0;
            lap_msec_reg <= '0;
            lap_sec_reg  <= '0;
            lap_min_reg  <= '0;
            lap_hour_reg <= '0;
        end else if (i_lap) begin
            if (!lap_hold_reg) begin
                lap_hold_reg <= 1'b1;
                lap_msec_reg <= msec_reg;
                lap_sec_reg  <= sec_reg;
                lap_min_reg  <= min_reg;
                lap_hour_reg <= hour_reg;
            end else begin
                lap_hold_reg <= 1'b0;
            end
        end
    end

    assign o_lap_hold = lap_hold_reg;
    assign o_msec     = lap_hold_reg ? lap_msec_reg : msec_reg;
    assign o_sec      = lap_hold_reg ? lap_sec_reg  : sec_reg;
    assign o_min      = lap_hold_reg ? lap_min_reg  : min_reg;
    assign o_hour     = lap_hold_reg ? lap_hour_reg : hour_reg;
`else
    assign o_msec = msec_reg;
    assign o_sec  = sec_reg;
    assign o_min  = min_reg;
    assign o_hour = hour_reg;
`endif

endmodule

// File: tb/tb_stopwatch_dp.sv
// Self-checking bench for stopwatch_dp: elapsed time modelled as a total centisecond count.
// A second instance with tiny moduli exercises the full 23:59:59.99 -> 0 wrap cheaply.
module tb_stopwatch_dp;

    localparam int TD       = 4;
    localparam int PERIOD   = 100 * 60 * 60 * 24;
    localparam int S_TD     = 2;
    localparam int S_PERIOD = 4 * 3 * 3 * 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_run, i_clear, i_lap;
    logic [6:0] o_msec;
    logic [5:0] o_sec, o_min;
    logic [4:0] o_hour;
    logic       o_lap_hold;

    logic       s_run, s_clear, s_lap;
    logic [6:0] s_msec;
    logic [5:0] s_sec, s_min;
    logic [4:0] s_hour;
    logic       s_lap_hold;

    int m_total = 0, m_frac = 0;
    int s_total = 0, s_frac = 0;
    int lap_total = 0;
    bit lap_hold = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stopwatch_dp #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_run      (i_run),
        .i_clear    (i_clear),
`ifdef STOPWATCH_DP_LAP_EN
        .i_lap      (i_lap),
        .o_lap_hold (o_lap_hold),
`endif
        .o_msec     (o_msec),
        .o_sec      (o_sec),
        .o_min      (o_min),
        .o_hour     (o_hour)
    );

    stopwatch_dp #(
        .TICK_DIV (S_TD),
        .MSEC_MAX (4),
        .SEC_MAX  (3),
        .MIN_MAX  (3),
        .HOUR_MAX (2)
    ) dut_small (
        .clk        (clk),
        .reset      (reset),
        .i_run      (s_run),
        .i_clear    (s_clear),
`ifdef STOPWATCH_DP_LAP_EN
        .i_lap      (s_lap),
        .o_lap_hold (s_lap_hold),
`endif
        .o_msec     (s_msec),
        .o_sec      (s_sec),
        .o_min      (s_min),
        .o_hour     (s_hour)
    );

`ifndef STOPWATCH_DP_LAP_EN
    assign o_lap_hold = 1'b0;
    assign s_lap_hold = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic adv(input logic run, input logic clear, inout int total, inout int frac,
                       input int td, input int period);
        if (clear) begin
            total = 0;
            frac  = 0;
        end else if (run) begin
            frac++;
            if (frac == td) begin
                frac  = 0;
                total = (total + 1) % period;
            end
        end
    endtask

    task automatic check_all();
        int disp;
        disp = lap_hold ? lap_total : m_total;
        chk("msec", o_msec, disp % 100);
        chk("sec",  o_sec,  (disp / 100) % 60);
        chk("min",  o_min,  (disp / 6000) % 60);
        chk("hour", o_hour, (disp / 360000) % 24);
        chk("s_msec", s_msec, s_total % 4);
        chk("s_sec",  s_sec,  (s_total / 4) % 3);
        chk("s_min",  s_min,  (s_total / 12) % 3);
        chk("s_hour", s_hour, (s_total / 36) % 2);
`ifdef STOPWATCH_DP_LAP_EN
        chk("lap_hold", o_lap_hold, int'(lap_hold));
`endif
    endtask

    task automatic zero_model();
        m_total = 0; m_frac = 0; s_total = 0; s_frac = 0;
        lap_total = 0; lap_hold = 1'b0;
    endtask

    // One clock: let the edge happen, advance the model with the sampled inputs, compare
    task automatic cyc();
        @(posedge clk);
        #1;
        if (reset) begin
            zero_model();
        end else begin
`ifdef STOPWATCH_DP_LAP_EN
            if (i_clear) begin
                lap_hold  = 1'b0;
                lap_total = 0;
            end else if (i_lap) begin
                if (!lap_hold) begin
                    lap_total = m_total;
                    lap_hold  = 1'b1;
                end else begin
                    lap_hold = 1'b0;
                end
            end
`endif
            adv(i_run, i_clear, m_total, m_frac, TD, PERIOD);
            adv(s_run, s_clear, s_total, s_frac, S_TD, S_PERIOD);
        end
        check_all();
    endtask

    task automatic run_until(input int target, input int budget, input string tag);
        int n = 0;
        while (m_total != target && n < budget) begin
            cyc();
            n++;
        end
        if (m_total != target) begin
            n_fail++;
            $error("FAIL %s: cycle budget %0d expired at total %0d, required %0d", tag, budget, m_total, target);
        end
    endtask

    task automatic show(input string tag);
        $display("[%s] %02d:%02d:%02d.%02d lap_hold=%0d", tag, o_hour, o_min, o_sec, o_msec, o_lap_hold);
    endtask

    initial begin
        int base;
        int n;

        reset = 1'b1; i_run = 1'b0; i_clear = 1'b0; i_lap = 1'b0;
        s_run = 1'b0; s_clear = 1'b0; s_lap = 1'b0;
        repeat (2) cyc();
        chk("reset_msec", o_msec, 0);
        show("reset");

        // First tick lands on the TD-th edge after run rises with the prescaler at 0
        reset = 1'b0;
        i_run = 1'b1;
        repeat (TD - 1) cyc();
        chk("pre_first_tick", o_msec, 0);
        cyc();
        chk("first_tick_msec", o_msec, 1);
        chk("first_tick_sec", o_sec, 0);
        show("first_tick");

        run_until(99, 500, "reach_0.99");
        chk("at_99_sec", o_sec, 0);
        run_until(100, TD + 1, "carry_to_1.00");
        chk("carry_sec", o_sec, 1);
        chk("carry_msec", o_msec, 0);
        show("sec_carry");

        // Pause with two prescaler counts banked, resume must need exactly two more clocks
        n = 0;
        while (m_frac != 2 && n < 10) begin cyc(); n++; end
        i_run = 1'b0;
        repeat (20) cyc();
        base = m_total;
        i_run = 1'b1;
        cyc();
        chk("resume_1clk", o_msec, base % 100);
        cyc();
        chk("resume_2clk", o_msec, (base + 1) % 100);
        show("pause_resume");

        repeat (400) begin
            i_run   = ($urandom_range(0, 7) != 0);
            i_clear = ($urandom_range(0, 39) == 0);
            cyc();
        end
        i_clear = 1'b0;
        i_run   = 1'b1;
        show("random");

        i_clear = 1'b1;
        cyc();
        i_clear = 1'b0;
        run_until(537, 3000, "reach_5.37");
        show("at_5.37");
        i_clear = 1'b1;
        repeat (3) begin
            cyc();
            chk("clear_msec", o_msec, 0);
            chk("clear_sec", o_sec, 0);
        end
        i_clear = 1'b0;
        show("clear");

        run_until(6203, 26000, "reach_1:02.03");
        show("at_1:02.03");
        #2;
        reset = 1'b1;
        #1;
        zero_model();
        chk("async_rst_msec", o_msec, 0);
        chk("async_rst_sec", o_sec, 0);
        chk("async_rst_min", o_min, 0);
        check_all();
        cyc();
        reset = 1'b0;
        show("async_reset");

        // Small instance: last value before wrap is total 71 (1:2:2.3 in its tiny moduli)
        i_run = 1'b0;
        s_run = 1'b1;
        n = 0;
        while (s_total != S_PERIOD - 1 && n < 400) begin cyc(); n++; end
        chk("pre_wrap_hour", s_hour, 1);
        n = 0;
        while (s_total == S_PERIOD - 1 && n < 10) begin cyc(); n++; end
        chk("wrap_msec", s_msec, 0);
        chk("wrap_sec", s_sec, 0);
        chk("wrap_min", s_min, 0);
        chk("wrap_hour", s_hour, 0);
        $display("[full_wrap] small %0d:%0d:%0d.%0d", s_hour, s_min, s_sec, s_msec);
        s_run = 1'b0;

`ifdef STOPWATCH_DP_LAP_EN
        i_clear = 1'b1;
        cyc();
        i_clear = 1'b0;
        i_run   = 1'b1;
        run_until(210, 1000, "reach_2.10");
        i_lap = 1'b1;
        cyc();
        i_lap = 1'b0;
        chk("lap_set", o_lap_hold, 1);
        repeat (10) cyc();
        chk("lap_frozen_msec", o_msec, 10);
        chk("lap_frozen_sec", o_sec, 2);
        show("lap_hold");
        run_until(300, 1000, "reach_3.00");
        i_lap = 1'b1;
        cyc();
        i_lap = 1'b0;
        chk("lap_release", o_lap_hold, 0);
        chk("lap_live_sec", o_sec, 3);
        chk("lap_live_msec", o_msec, 0);
        show("lap_release");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
